tia_player_scan_ctrl: RTL and testbench
=======================================

// Module: tia_player_scan_ctrl
// PURPOSE
//  Sequencer for one TIA player graphics datapath. Owns the 160-clock horizontal position
//  counter, decodes copy start points from NUSIZ, and drives the graphics shifter with
//  pixel-enable and bit-select at 1x/2x/4x stretch. Sits between the motion clock domain
//  and tia_player_graphics. The datapath keeps graphics storage and the VDEL mux.
// PARAMETERS
//  LINE_CLKS   160  position counter modulus (clocks per visible line)
//  CLOSE_OFS   16   counter value of close copy start
//  MED_OFS     32   counter value of medium copy start
//  WIDE_OFS    64   counter value of wide copy start
// PORTS
//  motck       in   1  motion clock; all state updates on rising edge
//  rst_bar     in   1  asynchronous reset, active-low
//  ec_bar      in   1  enable count, active-low; 1 = freeze all state (HMOVE gating)
//  resp        in   1  reset-position strobe; synchronous, one motck
//  nusiz       in   3  number/size code (NUSIZ bits 2:0)
//  refl        in   1  reflect; 1 = output D0 first
//  pos         out  8  current position counter, 0..LINE_CLKS-1
//  copy_start  out  1  one-cycle pulse: a copy scan began this cycle
//  px_en       out  1  datapath pixel enable; high while a scan is active
//  bit_sel     out  3  graphics bit for the current pixel
// BEHAVIOUR
//  Reset (rst_bar=0, async): pos=0, state=IDLE, idx=0, sub=0, px_en=0, copy_start=0,
//   bit_sel=7.
//  Freeze: ec_bar=1 holds every register. copy_start forced 0. px_en/bit_sel hold.
//  Position counter, evaluated only when ec_bar=0:
//   - resp=1: pos<=0 (priority over increment). Reaching 0 via resp is not a start match.
//   - else pos<=pos+1; 159 wraps to 0. Wrapping into 0 is a start match.
//  Start match (registered next-pos compare; copy_start asserted in cycle pos takes value):
//   - pos==0 reached by wrap: always matches (main copy)
//   - pos==CLOSE_OFS: nusiz in {001,011}
//   - pos==MED_OFS: nusiz in {010,011,110}
//   - pos==WIDE_OFS: nusiz in {100,110}
//   - nusiz 101 (2x) and 111 (4x): main copy only
//  Width W, latched from nusiz at each start: 101->2, 111->4, else 1.
//   Changing nusiz mid-scan does not alter the running scan.
//  FSM states:
//   - IDLE: px_en=0. On match go to SCAN with idx=0, sub=0, px_en=1.
//   - SCAN: px_en=1. Each enabled clock: if sub==W-1 then sub<=0, idx<=idx+1, else
//     sub<=sub+1. After idx==7 && sub==W-1, go to IDLE. Scan is exactly 8*W enabled clocks.
//   - Match while in SCAN: restart at idx=0, sub=0, W re-latched, copy_start pulses.
//     Restart wins over termination in the same cycle.
//  bit_sel: refl=0 -> 7-idx; refl=1 -> idx. refl is combinational; it takes effect on the
//   current pixel.
//  Latency: px_en and copy_start rise in the same cycle that pos shows the match value.
//   First pixel is bit_sel 7 (refl=0).
//  resp during SCAN: pos<=0 and the current scan aborts to IDLE with px_en=0 next cycle.
//   No new start occurs until the wrap.
//  Simultaneous resp and ec_bar=1: ignored (frozen).
//  Async reset mid-scan: immediate return to reset values. No pulse is emitted on
//   deassertion.
// TESTING
//  1. Reset, nusiz=000, ec_bar=0, 160 clocks -> pos wraps 159->0; copy_start and px_en rise
//     at pos=0; bit_sel steps 7..0 over 8 clocks; px_en low at pos=8.
//  2. nusiz=011 -> copy_start at pos 0, 16, 32 only; each scan 8 clocks; 24 px_en clocks
//     per line.
//  3. nusiz=111, refl=1 -> single scan of 32 clocks; bit_sel holds each of 0..7 for 4 clocks.
//  4. ec_bar=1 for 5 clocks mid-scan at idx=3 -> pos, idx, px_en frozen; resumes at idx=3,
//     total enabled scan length is still 8.
//  5. resp at pos=70 during idle, then run -> pos=0 after resp with no copy_start; the next
//     copy_start occurs 160 clocks later at the wrap.
//  6. Assert rst_bar=0 at idx=5 of a 2x scan -> outputs go to reset values without waiting
//     for motck.

Source files
------------

// File: rtl/tia_player_scan_ctrl.sv
// Player scan sequencer: 160-clock position counter, NUSIZ copy-start decode, and
// pixel-enable / bit-select generation for the player graphics shifter at 1x/2x/4x.
module tia_player_scan_ctrl #(
   parameter int LINE_CLKS = 160,
   parameter int CLOSE_OFS = 16,
   parameter int MED_OFS   = 32,
   parameter int WIDE_OFS  = 64
) (
   input  logic       motck,
   input  logic       rst_bar,
   input  logic       ec_bar,
   input  logic       resp,
   input  logic [2:0] nusiz,
   input  logic       refl,
   output logic [7:0] pos,
   output logic       copy_start,
   output logic       px_en,
   output logic [2:0] bit_sel
);

   localparam logic [7:0] POS_LAST  = 8'(LINE_CLKS - 1);
   localparam logic [7:0] POS_CLOSE = 8'(CLOSE_OFS);
   localparam logic [7:0] POS_MED   = 8'(MED_OFS);
   localparam logic [7:0] POS_WIDE  = 8'(WIDE_OFS);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pos_q, pos_d;
   logic [2:0] idx_q, idx_d;
   logic [1:0] sub_q, sub_d;
   logic [1:0] wm1_q, wm1_d;     // latched stretch width minus one (0, 1 or 3)
   logic       cs_q, cs_d;

   logic [7:0] pos_inc;
   logic       wrap;
   logic       hit_close, hit_med, hit_wide;
   logic       match;
   logic [1:0] wm1_new;

   // Start decode looks at the value pos is about to take, so the pulse and the
   // first pixel appear in the same cycle the counter shows the copy position.
   always_comb begin
      wrap      = (pos_q == POS_LAST);
      pos_inc   = wrap ? 8'd0 : pos_q + 8'd1;
      hit_close = (pos_inc == POS_CLOSE) && (nusiz == 3'b001 || nusiz == 3'b011);
      hit_med   = (pos_inc == POS_MED) &&
                  (nusiz == 3'b010 || nusiz == 3'b011 || nusiz == 3'b110);
      hit_wide  = (pos_inc == POS_WIDE) && (nusiz == 3'b100 || nusiz == 3'b110);
      match     = wrap || hit_close || hit_med || hit_wide;
      case (nusiz)
         3'b101:  wm1_new = 2'd1;
         3'b111:  wm1_new = 2'd3;
         default: wm1_new = 2'd0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      idx_d   = idx_q;
      sub_d   = sub_q;
      wm1_d   = wm1_q;
      cs_d    = 1'b0;
      if (!ec_bar) begin
         if (resp) begin
            // Position reset aborts any scan; the next start comes only from the wrap.
            pos_d   = 8'd0;
            state_d = S_IDLE;
            idx_d   = 3'd0;
            sub_d   = 2'd0;
         end else begin
            pos_d = pos_inc;
            if (match) begin
               state_d = S_SCAN;
               idx_d   = 3'd0;
               sub_d   = 2'd0;
               wm1_d   = wm1_new;
               cs_d    = 1'b1;
            end else if (state_q == S_SCAN) begin
               if (sub_q == wm1_q) begin
                  sub_d = 2'd0;
                  if (idx_q == 3'd7) begin
                     state_d = S_IDLE;
                     idx_d   = 3'd0;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else begin
                  sub_d = sub_q + 2'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge motck or negedge rst_bar) begin
      if (!rst_bar) begin
         state_q <= S_IDLE;
         pos_q   <= 8'd0;
         idx_q   <= 3'd0;
         sub_q   <= 2'd0;
         wm1_q   <= 2'd0;
         cs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         idx_q   <= idx_d;
         sub_q   <= sub_d;
         wm1_q   <= wm1_d;
         cs_q    <= cs_d;
      end
   end

   assign pos        = pos_q;
   assign copy_start = cs_q;
   assign px_en      = (state_q == S_SCAN);
   assign bit_sel    = refl ? idx_q : ~idx_q;

endmodule

// File: tb/tb_tia_player_scan_ctrl.sv
// Scoreboard bench for tia_player_scan_ctrl: a cycle model pushes expectations per
// driven clock, popped and compared after the edge, plus directed line-level checks.
module tb_tia_player_scan_ctrl;

   logic       motck = 1'b0;
   logic       rst_bar = 1'b0;
   logic       ec_bar = 1'b1;
   logic       resp = 1'b0;
   logic [2:0] nusiz = 3'd0;
   logic       refl = 1'b0;
   logic [7:0] pos;
   logic       copy_start;
   logic       px_en;
   logic [2:0] bit_sel;

   tia_player_scan_ctrl dut (
      .motck(motck), .rst_bar(rst_bar), .ec_bar(ec_bar), .resp(resp),
      .nusiz(nusiz), .refl(refl), .pos(pos), .copy_start(copy_start),
      .px_en(px_en), .bit_sel(bit_sel)
   );

   always #5 motck = ~motck;

   typedef struct packed {
      logic [7:0] pos;
      logic       cs;
      logic       px;
      logic [2:0] idx;
   } exp_t;

   exp_t q[$];
   int n_tests = 0, n_fail = 0;
   int n_cs = 0, n_px = 0, n_en_px = 0;
   logic [2:0] cur_n = 3'd0;
   logic       cur_rf = 1'b0;

   // reference model state: scan progress as a flat count of enabled clocks
   int m_pos = 0, m_cnt = 0, m_w = 1;
   bit m_act = 0, m_cs = 0;

   task automatic check(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit start_hit(input int p, input bit wr, input int n);
      return (p == 0 && wr) ||
             (p == 16 && (n == 1 || n == 3)) ||
             (p == 32 && (n == 2 || n == 3 || n == 6)) ||
             (p == 64 && (n == 4 || n == 6));
   endfunction

   task automatic model_reset();
      m_pos = 0; m_cnt = 0; m_w = 1; m_act = 0; m_cs = 0;
   endtask

   task automatic step(input logic r, input logic e);
      exp_t ex;
      bit   wr, hit;
      int   eb;
      resp = r; ec_bar = e; nusiz = cur_n; refl = cur_rf;
      if (!e && px_en) n_en_px++;
      if (e) m_cs = 0;
      else if (r) begin
         m_pos = 0; m_act = 0; m_cnt = 0; m_cs = 0;
      end else begin
         wr    = (m_pos == 159);
         m_pos = wr ? 0 : m_pos + 1;
         hit   = start_hit(m_pos, wr, int'(cur_n));
         m_cs  = hit;
         if (hit) begin
            m_act = 1; m_cnt = 0;
            m_w = (cur_n == 3'b101) ? 2 : (cur_n == 3'b111) ? 4 : 1;
         end else if (m_act) begin
            m_cnt++;
            if (m_cnt == 8 * m_w) begin m_act = 0; m_cnt = 0; end
         end
      end
      ex.pos = 8'(m_pos); ex.cs = m_cs; ex.px = m_act;
      ex.idx = m_act ? 3'(m_cnt / m_w) : 3'd0;
      q.push_back(ex);
      @(posedge motck); #1;
      ex = q.pop_front();
      eb = cur_rf ? int'(ex.idx) : 7 - int'(ex.idx);
      check("pos", int'(pos), int'(ex.pos));
      check("copy_start", int'(copy_start), int'(ex.cs));
      check("px_en", int'(px_en), int'(ex.px));
      check("bit_sel", int'(bit_sel), eb);
      if (copy_start) n_cs++;
      if (px_en) n_px++;
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 200 && m_pos != target; i++) step(1'b0, 1'b0);
      check("run_to", int'(pos), target);
   endtask

   task automatic clr_counts();
      n_cs = 0; n_px = 0; n_en_px = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      // reset state
      #3;
      check("rst_pos", int'(pos), 0);
      check("rst_cs", int'(copy_start), 0);
      check("rst_px", int'(px_en), 0);
      check("rst_bit", int'(bit_sel), 7);
      #9 rst_bar = 1'b1;
      model_reset();

      // 1: plain line, main copy at the wrap only
      cur_n = 3'b000; cur_rf = 1'b0; clr_counts();
      for (int i = 0; i < 168; i++) step(1'b0, 1'b0);
      check("t1_cs", n_cs, 1);
      check("t1_px", n_px, 8);

      // 2: three close+medium copies per line
      cur_n = 3'b011;
      run_to(159); clr_counts();
      for (int i = 0; i < 160; i++) step(1'b0, 1'b0);
      check("t2_cs", n_cs, 3);
      check("t2_px", n_px, 24);

      // 3: quad width, reflected
      cur_n = 3'b111; cur_rf = 1'b1;
      run_to(159); clr_counts();
      for (int i = 0; i < 160; i++) step(1'b0, 1'b0);
      check("t3_cs", n_cs, 1);
      check("t3_px", n_px, 32);

      // 4: freeze mid-scan at idx 3
      cur_n = 3'b000; cur_rf = 1'b0;
      run_to(159); clr_counts();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      check("t4_idx3", int'(bit_sel), 4);
      step(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      check("t4_frozen_pos", int'(pos), 3);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
      check("t4_len", n_en_px, 8);

      // 5: resp while idle; ec_bar=1 resp ignored, then real resp
      run_to(70);
      step(1'b1, 1'b1);
      check("t5_frozen_resp", int'(pos), 70);
      step(1'b1, 1'b0);
      check("t5_resp_pos", int'(pos), 0);
      k = 0;
      for (int i = 1; i <= 200 && k == 0; i++) begin
         step(1'b0, 1'b0);
         if (copy_start) k = i;
      end
      check("t5_gap", k, 160);

      // 5b: resp during a scan aborts it
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check("t5_abort_px", int'(px_en), 0);

      // 6: async reset at idx 5 of a 2x scan
      cur_n = 3'b101;
      run_to(159);
      for (int i = 0; i < 11; i++) step(1'b0, 1'b0);
      check("t6_idx5", int'(bit_sel), 2);
      #2 rst_bar = 1'b0;
      #1;
      check("t6_pos", int'(pos), 0);
      check("t6_cs", int'(copy_start), 0);
      check("t6_px", int'(px_en), 0);
      check("t6_bit", int'(bit_sel), 7);
      model_reset();
      @(negedge motck) rst_bar = 1'b1;
      clr_counts();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
      check("t6_no_pulse", n_cs, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
